// File: rtl/lcd_bus_pkg.sv
// Shared types and constants for the LCD write-bus arbiter and its strobe engine.
package lcd_bus_pkg;

  // Bus sequencing states. The arbiter uses IDLE/SETUP/BURST_WAIT/CS_REL, where
  // its SETUP spans the whole beat (SETUP, WR_LOW and WR_HIGH). The strobe
  // engine steps through IDLE/SETUP/WR_LOW/WR_HIGH inside that beat.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SETUP      = 3'd1,
    ST_WR_LOW     = 3'd2,
    ST_WR_HIGH    = 3'd3,
    ST_BURST_WAIT = 3'd4,
    ST_CS_REL     = 3'd5
  } arb_state_t;

  // Owner encoding used on owner_o and for the burst lock.
  localparam logic OWNER_CFG = 1'b0;
  localparam logic OWNER_PIX = 1'b1;

  // Width of every phase counter. Counters load (cycles - 1) and count down to 0.
  localparam int PHASE_W = 4;

endpackage

// File: rtl/lcd_wr_strobe_gen.sv
// Per-beat write strobe timing: one SETUP cycle, then wr_n low for
// WR_LOW_CYCLES and high for WR_HIGH_CYCLES. done pulses in the last
// WR_HIGH cycle. wr_n is registered.
module lcd_wr_strobe_gen
  import lcd_bus_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic done,
  output logic wr_n
);

  localparam logic [PHASE_W-1:0] LOW_LOAD  = PHASE_W'(WR_LOW_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HIGH_LOAD = PHASE_W'(WR_HIGH_CYCLES - 1);

  arb_state_t         state_reg, state_next;
  logic [PHASE_W-1:0] cnt_reg, cnt_next;
  logic               wr_n_reg;

  // Next phase and countdown; done marks the final WR_HIGH cycle.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        state_next = ST_WR_LOW;
        cnt_next   = LOW_LOAD;
      end
      ST_WR_LOW: begin
        if (cnt_reg == '0) begin
          state_next = ST_WR_HIGH;
          cnt_next   = HIGH_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      ST_WR_HIGH: begin
        if (cnt_reg == '0) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Phase register; wr_n is decoded from the next phase so the pin is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      wr_n_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_n_reg  <= (state_next != ST_WR_LOW);
    end
  end

  assign wr_n = wr_n_reg;

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Arbiter/sequencer for the shared 8080-style LCD write bus. cfg wins over pix,
// pix needs init_done_i, and a granted burst keeps the bus until its last beat.
// Optional beat counters are built when LCD_ARB_STATS_EN is defined.
module lcd_bus_arbiter
  import lcd_bus_pkg::*;
#(
  parameter int WR_LOW_CYCLES  = 2,
  parameter int WR_HIGH_CYCLES = 2,
  parameter int CS_IDLE_CYCLES = 1
) (
  input  logic        sys_clk_i,
  input  logic        reset_i,
  input  logic        init_done_i,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic        cfg_dc_i,
  input  logic [7:0]  cfg_data_i,
  input  logic        cfg_last_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  logic        pix_dc_i,
  input  logic [7:0]  pix_data_i,
  input  logic        pix_last_i,
  output logic        cs_o,
  output logic        dc_o,
  output logic        wr_o,
  output logic        rd_o,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic        owner_o
`ifdef LCD_ARB_STATS_EN
  ,
  output logic [15:0] cfg_beats_o,
  output logic [15:0] pix_beats_o
`endif
);

  localparam logic [PHASE_W-1:0] REL_LOAD = PHASE_W'(CS_IDLE_CYCLES - 1);

  arb_state_t         state_reg, state_next;
  logic [PHASE_W-1:0] rel_cnt_reg, rel_cnt_next;
  logic               dc_reg, last_reg, owner_reg, cs_n_reg;
  logic [7:0]         data_reg;
  logic               grant_cfg, grant_pix, hs;
  logic               strobe_done, strobe_wr_n;

  // Grants depend only on registered state plus valids; in BURST_WAIT the
  // owner alone is offered ready so the burst lock cannot be broken.
  assign grant_cfg = ((state_reg == ST_IDLE) && cfg_valid_i) ||
                     ((state_reg == ST_BURST_WAIT) && (owner_reg == OWNER_CFG));
  assign grant_pix = ((state_reg == ST_IDLE) && !cfg_valid_i && pix_valid_i && init_done_i) ||
                     ((state_reg == ST_BURST_WAIT) && (owner_reg == OWNER_PIX));
  assign hs        = (grant_cfg && cfg_valid_i) || (grant_pix && pix_valid_i);

  // Arbiter next state; SETUP here covers the whole beat run by the strobe engine.
  always_comb begin
    state_next   = state_reg;
    rel_cnt_next = rel_cnt_reg;
    case (state_reg)
      ST_IDLE, ST_BURST_WAIT: begin
        if (hs) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        if (strobe_done) begin
          if (last_reg) begin
            state_next   = ST_CS_REL;
            rel_cnt_next = REL_LOAD;
          end else begin
            state_next = ST_BURST_WAIT;
          end
        end
      end
      ST_CS_REL: begin
        if (rel_cnt_reg == '0) state_next = ST_IDLE;
        else                   rel_cnt_next = rel_cnt_reg - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, captured beat and registered chip select.
  always_ff @(posedge sys_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg   <= ST_IDLE;
      rel_cnt_reg <= '0;
      dc_reg      <= 1'b0;
      data_reg    <= 8'h00;
      last_reg    <= 1'b0;
      owner_reg   <= OWNER_CFG;
      cs_n_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      rel_cnt_reg <= rel_cnt_next;
      cs_n_reg    <= !((state_next == ST_SETUP) || (state_next == ST_BURST_WAIT));
      if (hs) begin
        dc_reg    <= grant_pix ? pix_dc_i   : cfg_dc_i;
        data_reg  <= grant_pix ? pix_data_i : cfg_data_i;
        last_reg  <= grant_pix ? pix_last_i : cfg_last_i;
        owner_reg <= grant_pix ? OWNER_PIX  : OWNER_CFG;
      end
    end
  end

  lcd_wr_strobe_gen #(
    .WR_LOW_CYCLES (WR_LOW_CYCLES),
    .WR_HIGH_CYCLES(WR_HIGH_CYCLES)
  ) u_strobe (
    .clk  (sys_clk_i),
    .rst  (reset_i),
    .start(hs),
    .done (strobe_done),
    .wr_n (strobe_wr_n)
  );

  assign cfg_ready_o = grant_cfg;
  assign pix_ready_o = grant_pix;
  assign cs_o        = cs_n_reg;
  assign wr_o        = strobe_wr_n;
  assign rd_o        = 1'b1;
  assign dc_o        = dc_reg;
  assign data_o      = data_reg;
  assign busy_o      = (state_reg != ST_IDLE);
  assign owner_o     = owner_reg;

`ifdef LCD_ARB_STATS_EN
  // One saturating completed-beat counter per requester, indexed by owner code.
  for (genvar gi = 0; gi < 2; gi++) begin : g_beats
    logic [15:0] cnt_reg;
    always_ff @(posedge sys_clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_reg <= 16'h0000;
      end else if (strobe_done && (owner_reg == 1'(gi)) && (cnt_reg != 16'hFFFF)) begin
        cnt_reg <= cnt_reg + 16'h0001;
      end
    end
  end
  assign cfg_beats_o = g_beats[0].cnt_reg;
  assign pix_beats_o = g_beats[1].cnt_reg;
`endif

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Self-checking bench for lcd_bus_arbiter: a beat-timeline model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_lcd_bus_arbiter;

  localparam int L = 2;
  localparam int H = 2;
  localparam int C = 1;
  localparam int B = 1 + L + H;  // cycles from SETUP to the last WR_HIGH cycle

  logic       sys_clk_i = 1'b0;
  logic       reset_i;
  logic       init_done_i;
  logic       cfg_valid_i, cfg_dc_i, cfg_last_i;
  logic       pix_valid_i, pix_dc_i, pix_last_i;
  logic [7:0] cfg_data_i, pix_data_i;
  logic       cfg_ready_o, pix_ready_o, cs_o, dc_o, wr_o, rd_o, busy_o, owner_o;
  logic [7:0] data_o;
`ifdef LCD_ARB_STATS_EN
  logic [15:0] cfg_beats_o, pix_beats_o;
`endif

  always #5 sys_clk_i = ~sys_clk_i;

  lcd_bus_arbiter #(
    .WR_LOW_CYCLES (L),
    .WR_HIGH_CYCLES(H),
    .CS_IDLE_CYCLES(C)
  ) dut (
    .sys_clk_i  (sys_clk_i),
    .reset_i    (reset_i),
    .init_done_i(init_done_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_dc_i   (cfg_dc_i),
    .cfg_data_i (cfg_data_i),
    .cfg_last_i (cfg_last_i),
    .pix_valid_i(pix_valid_i),
    .pix_ready_o(pix_ready_o),
    .pix_dc_i   (pix_dc_i),
    .pix_data_i (pix_data_i),
    .pix_last_i (pix_last_i),
    .cs_o       (cs_o),
    .dc_o       (dc_o),
    .wr_o       (wr_o),
    .rd_o       (rd_o),
    .data_o     (data_o),
    .busy_o     (busy_o),
    .owner_o    (owner_o)
`ifdef LCD_ARB_STATS_EN
    ,
    .cfg_beats_o(cfg_beats_o),
    .pix_beats_o(pix_beats_o)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: m_k = position inside the current beat (0 = none), m_lock = burst
  // waiting for its owner, m_rel = chip-select release cycles still to go.
  int         m_k, m_rel;
  bit         m_lock, m_owner, m_dc, m_last;
  logic [7:0] m_data;
  int         m_cnt [2];

  // Observations taken at the falling edge of each stepped cycle.
  logic obs_cs, obs_wr, obs_busy, obs_cfg_rdy, obs_pix_rdy, obs_cfg_hs, obs_pix_hs, prev_wr;
  logic [7:0] obs_data, tgt_data;
  int n_wr_low, n_cs_low, n_cs_low_tgt, n_rel, n_cfg_rdy, n_pix_rdy;
  logic [7:0] fall_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_rel = 0; m_lock = 0; m_owner = 0; m_dc = 0; m_last = 0;
    m_data = 8'h00; m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  task automatic clear_obs();
    n_wr_low = 0; n_cs_low = 0; n_cs_low_tgt = 0; n_rel = 0; n_cfg_rdy = 0; n_pix_rdy = 0;
    fall_q.delete();
  endtask

  // One cycle: compare DUT against model, record observations, advance model.
  task automatic step();
    bit idle, e_cs, e_wr, e_busy, e_crdy, e_prdy, hc, hp;
    @(negedge sys_clk_i);
    idle   = (m_k == 0) && !m_lock && (m_rel == 0);
    e_cs   = !((m_k != 0) || m_lock);
    e_wr   = !((m_k >= 2) && (m_k <= 1 + L));
    e_busy = !idle;
    e_crdy = idle ? cfg_valid_i : (m_lock && (m_owner == 1'b0));
    e_prdy = idle ? (!cfg_valid_i && pix_valid_i && init_done_i) : (m_lock && (m_owner == 1'b1));
    check("cs_o", 32'(cs_o), 32'(e_cs));
    check("wr_o", 32'(wr_o), 32'(e_wr));
    check("rd_o", 32'(rd_o), 32'd1);
    check("busy_o", 32'(busy_o), 32'(e_busy));
    check("cfg_ready_o", 32'(cfg_ready_o), 32'(e_crdy));
    check("pix_ready_o", 32'(pix_ready_o), 32'(e_prdy));
    check("owner_o", 32'(owner_o), 32'(m_owner));
    check("dc_o", 32'(dc_o), 32'(m_dc));
    check("data_o", 32'(data_o), 32'(m_data));
`ifdef LCD_ARB_STATS_EN
    check("cfg_beats_o", 32'(cfg_beats_o), 32'(m_cnt[0]));
    check("pix_beats_o", 32'(pix_beats_o), 32'(m_cnt[1]));
`endif
    obs_cs = cs_o; obs_wr = wr_o; obs_busy = busy_o; obs_data = data_o;
    obs_cfg_rdy = cfg_ready_o; obs_pix_rdy = pix_ready_o;
    obs_cfg_hs = cfg_valid_i && cfg_ready_o;
    obs_pix_hs = pix_valid_i && pix_ready_o;
    if (!wr_o) n_wr_low++;
    if (!cs_o) n_cs_low++;
    if (!cs_o && data_o == tgt_data) n_cs_low_tgt++;
    if (cs_o && busy_o) n_rel++;
    if (cfg_ready_o) n_cfg_rdy++;
    if (pix_ready_o) n_pix_rdy++;
    if (!wr_o && prev_wr) fall_q.push_back(data_o);
    prev_wr = wr_o;
    hc = e_crdy && cfg_valid_i;
    hp = e_prdy && pix_valid_i;
    if (m_k != 0) begin
      if (m_k == B) begin
        if (m_cnt[int'(m_owner)] < 65535) m_cnt[int'(m_owner)]++;
        m_k = 0;
        if (m_last) m_rel = C;
        else        m_lock = 1;
      end else begin
        m_k++;
      end
    end else if (m_rel != 0) begin
      m_rel--;
    end else if (hc || hp) begin
      m_k = 1; m_lock = 0; m_owner = hp;
      m_dc   = hp ? pix_dc_i   : cfg_dc_i;
      m_data = hp ? pix_data_i : cfg_data_i;
      m_last = hp ? pix_last_i : cfg_last_i;
    end
    @(posedge sys_clk_i);
    #1;
    cyc++;
  endtask

  task automatic send_cfg(input logic dc, input logic [7:0] d, input logic last, output int hs_cyc);
    bit got;
    cfg_valid_i = 1; cfg_dc_i = dc; cfg_data_i = d; cfg_last_i = last;
    got = 0; hs_cyc = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (obs_cfg_hs) begin got = 1; hs_cyc = cyc - 1; end
    end
    if (!got) check("cfg_hs_timeout", 32'd0, 32'd1);
    cfg_valid_i = 0;
  endtask

  task automatic wait_idle();
    bit done_w;
    done_w = 0;
    for (int i = 0; i < 100 && !done_w; i++) begin
      step();
      if (!obs_busy) done_w = 1;
    end
    if (!done_w) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int h0, h1;
    bit got;
    reset_i = 1; init_done_i = 0;
    cfg_valid_i = 0; cfg_dc_i = 0; cfg_data_i = 0; cfg_last_i = 0;
    pix_valid_i = 0; pix_dc_i = 0; pix_data_i = 0; pix_last_i = 0;
    prev_wr = 1; tgt_data = 8'h00;
    model_reset(); clear_obs();
    repeat (2) @(posedge sys_clk_i);
    #1 reset_i = 0;

    // Reset then idle
    repeat (3) step();
    check("idle_cs", 32'(obs_cs), 32'd1);
    check("idle_wr", 32'(obs_wr), 32'd1);
    check("idle_rdy", {30'd0, obs_cfg_rdy, obs_pix_rdy}, 32'd0);
    check("idle_busy", 32'(obs_busy), 32'd0);
    check("idle_data", 32'(obs_data), 32'h00);
    $display("txn reset_idle cs=%0b wr=%0b busy=%0b", obs_cs, obs_wr, obs_busy);

    // Single cfg command beat 0x2C
    clear_obs(); tgt_data = 8'h2C;
    send_cfg(1'b0, 8'h2C, 1'b1, h0);
    wait_idle();
    check("single_wr_low_cycles", 32'(n_wr_low), 32'd2);
    check("single_cs_low_cycles", 32'(n_cs_low), 32'd5);
    check("single_data_during_cs", 32'(n_cs_low_tgt), 32'(n_cs_low));
    check("single_cs_rel_cycles", 32'(n_rel), 32'd1);
    $display("txn cfg_single data=2c wr_low=%0d cs_low=%0d rel=%0d", n_wr_low, n_cs_low, n_rel);

    // Simultaneous requests: cfg first, pix after release
    init_done_i = 1;
    pix_valid_i = 1; pix_dc_i = 1; pix_data_i = 8'h55; pix_last_i = 1;
    cfg_valid_i = 1; cfg_dc_i = 0; cfg_data_i = 8'h36; cfg_last_i = 1;
    step();
    check("simul_cfg_grant", 32'(obs_cfg_hs), 32'd1);
    check("simul_pix_ready", 32'(obs_pix_rdy), 32'd0);
    check("simul_owner_cfg", 32'(owner_o), 32'd0);
    h0 = cyc - 1; cfg_valid_i = 0; got = 0; h1 = -1;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (obs_pix_hs) begin got = 1; h1 = cyc - 1; end
    end
    pix_valid_i = 0;
    check("simul_pix_delay", 32'(h1 - h0), 32'd7);
    check("simul_owner_pix", 32'(owner_o), 32'd1);
    wait_idle();
    $display("txn simultaneous cfg_hs=%0d pix_hs=%0d", h0, h1);

    // Pix burst 11..44 with cfg raised during beat 2
    clear_obs(); h0 = -1; h1 = -1;
    for (int b = 0; b < 4; b++) begin
      pix_valid_i = 1; pix_dc_i = 1; pix_data_i = 8'(8'h11 * (b + 1)); pix_last_i = (b == 3);
      if (b == 1) begin cfg_valid_i = 1; cfg_dc_i = 0; cfg_data_i = 8'h3A; cfg_last_i = 1; end
      if (b == 1) begin n_cs_low = 0; n_rel = 0; n_cfg_rdy = 0; end
      got = 0;
      for (int i = 0; i < 60 && !got; i++) begin
        step();
        if (obs_pix_hs) begin got = 1; h0 = cyc - 1; end
      end
      if (!got) check("burst_pix_timeout", 32'd0, 32'd1);
      pix_valid_i = 0;
    end
    check("burst_cs_held_low", 32'(n_rel), 32'd0);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      step();
      if (obs_cfg_hs) begin got = 1; h1 = cyc - 1; end
    end
    cfg_valid_i = 0;
    check("burst_cfg_ready_held", 32'(n_cfg_rdy), 32'd1);
    check("burst_cfg_after_rel", 32'(h1 - h0), 32'd7);
    wait_idle();
    check("burst_beats", 32'(fall_q.size()), 32'd5);
    if (fall_q.size() >= 4) begin
      for (int b = 0; b < 4; b++)
        check("burst_data_order", 32'(fall_q[b]), 32'(8'h11 * (b + 1)));
    end
    $display("txn pix_burst beats=%0d cfg_wait=%0d", fall_q.size(), h1 - h0);

    // pix gated by init_done
    clear_obs();
    init_done_i = 0; pix_valid_i = 1; pix_data_i = 8'hA5; pix_last_i = 1;
    repeat (20) step();
    check("gated_pix_ready", 32'(n_pix_rdy), 32'd0);
    check("gated_busy", 32'(obs_busy), 32'd0);
    init_done_i = 1;
    step();
    check("ungated_grant", 32'(obs_pix_hs), 32'd1);
    pix_valid_i = 0;
    wait_idle();
    $display("txn init_gate ready_while_gated=%0d", n_pix_rdy);

    // Reset asserted during WR_LOW
    send_cfg(1'b1, 8'h99, 1'b1, h0);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (!obs_wr) got = 1;
    end
    check("pre_reset_wr_low", 32'(wr_o), 32'd0);
    #2 reset_i = 1;
    #1;
    check("async_reset_cs", 32'(cs_o), 32'd1);
    check("async_reset_wr", 32'(wr_o), 32'd1);
    check("async_reset_busy", 32'(busy_o), 32'd0);
`ifdef LCD_ARB_STATS_EN
    check("reset_cfg_beats", 32'(cfg_beats_o), 32'd0);
    check("reset_pix_beats", 32'(pix_beats_o), 32'd0);
`endif
    @(posedge sys_clk_i);
    #1 reset_i = 0;
    model_reset(); prev_wr = 1;
    repeat (3) step();
    check("post_reset_idle", 32'(obs_busy), 32'd0);
    $display("txn reset_mid_beat cs=%0b wr=%0b", obs_cs, obs_wr);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if (obs_cfg_hs || !cfg_valid_i) begin
        if ($urandom_range(0, 5) != 0 && !(obs_cfg_hs && !cfg_last_i)) cfg_valid_i = 0;
        else begin
          cfg_valid_i = 1; cfg_dc_i = 1'($urandom); cfg_data_i = 8'($urandom);
          cfg_last_i = ($urandom_range(0, 2) == 0);
        end
      end
      if (obs_pix_hs || !pix_valid_i) begin
        if ($urandom_range(0, 3) == 0) pix_valid_i = 0;
        else begin
          pix_valid_i = 1; pix_dc_i = 1'($urandom); pix_data_i = 8'($urandom);
          pix_last_i = ($urandom_range(0, 3) == 0);
        end
      end
      if ($urandom_range(0, 39) == 0) init_done_i = ~init_done_i;
      step();
      if (obs_cfg_hs) $display("txn rand cyc=%0d cfg data=%02h", cyc - 1, cfg_data_i);
      if (obs_pix_hs) $display("txn rand cyc=%0d pix data=%02h", cyc - 1, pix_data_i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_bus_arbiter.md
# lcd_bus_arbiter

Sequencer and arbiter for the shared 8-bit 8080-style LCD write bus. It shares the bus between two requesters: the APB configuration path, which sends controller init commands, and the camera line path, which streams pixel bytes. It owns the bus's cs/dc/wr/data timing. It sits between those two sources and the LCD pins, and replaces the static select-by-init-done mux with handshaked, burst-locked arbitration.

## Interface
Parameters:
- WR_LOW_CYCLES, default 2: cycles wr_o is held low per beat; legal range 1..15.
- WR_HIGH_CYCLES, default 2: cycles wr_o is held high after the rising edge, before the next beat may start; legal range 1..15.
- CS_IDLE_CYCLES, default 1: cycles cs_o is held high between bursts; legal range 1..15.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - sys_clk_i, in, 1: system clock (GL0 domain).
  - reset_i, in, 1: asynchronous reset, active-high.
- Control:
  - init_done_i, in, 1: pixel requester is eligible only while this is 1.
- Configuration requester:
  - cfg_valid_i, in, 1: configuration beat offered.
  - cfg_ready_o, out, 1: configuration beat accepted on valid&ready.
  - cfg_dc_i, in, 1: 0 = command, 1 = data.
  - cfg_data_i, in, 8: configuration byte.
  - cfg_last_i, in, 1: final beat of a configuration burst.
- Pixel requester:
  - pix_valid_i, pix_ready_o, pix_dc_i, pix_data_i[7:0], pix_last_i: same semantics as the cfg_* ports.
- LCD bus:
  - cs_o, out, 1: LCD chip select, active-low.
  - dc_o, out, 1: LCD register select.
  - wr_o, out, 1: LCD write strobe, active-low.
  - rd_o, out, 1: constant 1.
  - data_o, out, 8: LCD data bus.
- Status:
  - busy_o, out, 1: 1 whenever state ≠ IDLE.
  - owner_o, out, 1: current or last grant; 0 = cfg, 1 = pix.

## Operation
States are IDLE, SETUP, WR_LOW, WR_HIGH, BURST_WAIT and CS_REL.

- **IDLE**
  - cs_o=1, wr_o=1.
  - Grant rule: cfg_valid_i wins, whether or not pix_valid_i is high. Otherwise pix_valid_i&&init_done_i wins.
  - The granted requester's ready_o is asserted combinationally in the same cycle.
  - On handshake:
    - capture dc, data and last into registers;
    - set owner_o;
    - go to SETUP.
- **SETUP** (1 cycle)
  - cs_o=0, wr_o=1.
  - dc_o and data_o driven from the captured registers.
- **WR_LOW**
  - wr_o=0 for WR_LOW_CYCLES cycles.
  - dc_o and data_o stable.
- **WR_HIGH**
  - wr_o=1 for WR_HIGH_CYCLES cycles.
  - dc_o and data_o held until the end of this state.
  - Exit: captured last=1 → CS_REL; otherwise → BURST_WAIT.
- **BURST_WAIT**
  - cs_o stays 0.
  - Only the owner's ready_o is asserted. The other requester is ignored even if its valid is high, so the burst lock holds.
  - Handshake → SETUP.
- **CS_REL**
  - cs_o=1 for CS_IDLE_CYCLES cycles, then → IDLE.
- Neither ready_o is ever high outside IDLE and BURST_WAIT. Both are never high together.
- If init_done_i falls during a pixel burst, the burst continues to pix last. init_done_i gates only new grants.
- Phase counter: 4 bits, loaded with parameter−1, decrements to 0. Parameter value 0 is illegal.

## Timing
- Reset values:
  - cs_o=1, wr_o=1, rd_o=1, dc_o=0, data_o=8'h00;
  - cfg_ready_o=0, pix_ready_o=0;
  - busy_o=0, owner_o=0;
  - state IDLE.
- Reset asserted mid-transfer forces cs_o and wr_o to 1 asynchronously and abandons the beat. No partial wr pulse is resumed.
- Beat period inside a burst: 1 (handshake) + 1 (SETUP) + WR_LOW_CYCLES + WR_HIGH_CYCLES. With defaults this is 6 cycles.
- Handshake to first wr_o falling edge: 2 cycles.
- With a continuously valid owner, BURST_WAIT lasts exactly 1 cycle.
- All LCD outputs are registered. No combinational path exists from inputs to the LCD pins.

## Configuration
- Macro LCD_ARB_STATS_EN.
- Defined:
  - adds outputs cfg_beats_o[15:0] and pix_beats_o[15:0];
  - each counts completed beats, incrementing on the WR_HIGH→exit transition;
  - counters saturate at 16'hFFFF;
  - counters clear on reset_i.
- Undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package lcd_bus_pkg holds:
  - the state enum type;
  - the owner encoding constants OWNER_CFG=1'b0 and OWNER_PIX=1'b1;
  - the counter width constant PHASE_W=4.
- One sub-module, lcd_wr_strobe_gen: the SETUP/WR_LOW/WR_HIGH timing engine.
  - Interface: start pulse, done pulse, wr_n output.
  - The arbiter FSM drives start and holds the data/dc registers.

## Test plan
- Reset, then idle: no valid inputs → cs_o=1, wr_o=1, both readys 0, busy_o=0, data_o=8'h00.
- Single cfg beat (dc=0, data=8'h2C, last=1), default parameters:
  - wr_o low exactly 2 cycles;
  - data_o=8'h2C throughout cs_o low;
  - cs_o high 1 cycle after the beat;
  - then idle.
- Simultaneous cfg_valid and pix_valid in IDLE with init_done_i=1 → cfg granted first (owner_o=0). pix is served only after the cfg burst's last beat plus CS_REL.
- Pix burst of 4 bytes 8'h11..8'h44 with cfg_valid raised at beat 2:
  - all 4 pix beats complete, cs_o held 0 throughout;
  - cfg_ready_o stays 0 until CS_REL ends.
- pix_valid=1 while init_done_i=0 → no grant and pix_ready_o=0 indefinitely. Raising init_done_i → grant next cycle.
- reset_i pulsed during WR_LOW → cs_o and wr_o go 1 the same cycle, the FSM returns to IDLE, and with LCD_ARB_STATS_EN defined both counters read 0.
